// File: rtl/hilbert_frame_feeder_pkg.sv
// Shared definitions for the Hilbert frame feeder: FSM encoding and default sizes.
package hilbert_frame_feeder_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int N_TAPS_DEF  = 16;
  localparam int ADDR_W_DEF  = 8;
  localparam int ACC_W_DEF   = 36;
  localparam int TMO_CYC_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFETCH  = 3'd1,
    ST_STREAM    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLD_RES  = 3'd4
  } feed_state_e;

endpackage

// File: rtl/hilbert_frame_feeder_addr_gen.sv
// Address generator for one frame: wrapping sample address, coefficient
// index and beat counter. Addresses run one beat ahead of the data beats
// and stop at the last tap so the RAMs are never read past the frame.
module hilbert_frame_feeder_addr_gen
  import hilbert_frame_feeder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int CW     = $clog2(N_TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              prefetch,
  input  logic              stream,
  output logic [ADDR_W-1:0] smp_addr,
  output logic [CW-1:0]     coef_addr,
  output logic [CW-1:0]     beat_cnt,
  output logic              last_beat
);

  logic [ADDR_W-1:0] smp_addr_r;
  logic [CW-1:0]     coef_addr_r;
  logic [CW-1:0]     beat_cnt_r;
  logic              advance_s;

  // Advance addresses in PREFETCH and in STREAM until the last tap is addressed.
  always_comb begin
    advance_s = 1'b0;
    if (prefetch) begin
      advance_s = 1'b1;
    end else if (stream && (beat_cnt_r < CW'(N_TAPS - 2))) begin
      advance_s = 1'b1;
    end else begin
      advance_s = 1'b0;
    end
  end

  // Address and beat counter registers; sample address wraps modulo 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_addr_r  <= {ADDR_W{1'b0}};
      coef_addr_r <= {CW{1'b0}};
      beat_cnt_r  <= {CW{1'b0}};
    end else if (load) begin
      smp_addr_r  <= base;
      coef_addr_r <= {CW{1'b0}};
      beat_cnt_r  <= {CW{1'b0}};
    end else begin
      if (advance_s) begin
        smp_addr_r  <= smp_addr_r + ADDR_W'(1);
        coef_addr_r <= coef_addr_r + CW'(1);
      end
      if (stream) begin
        beat_cnt_r <= beat_cnt_r + CW'(1);
      end
    end
  end

  assign smp_addr  = smp_addr_r;
  assign coef_addr = coef_addr_r;
  assign beat_cnt  = beat_cnt_r;
  assign last_beat = (beat_cnt_r == CW'(N_TAPS - 1));

endmodule

// File: rtl/hilbert_frame_feeder.sv
// Initiator between sample/coefficient RAMs and the Hilbert transform core:
// streams one frame of N_TAPS beats, waits for the core result and holds it
// on a valid/ready port. All outputs are registered.
module hilbert_frame_feeder
  import hilbert_frame_feeder_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_TAPS  = N_TAPS_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_req,
  input  logic [ADDR_W-1:0]         frame_base,
  output logic [ADDR_W-1:0]         smp_addr,
  input  logic [DATA_W-1:0]         smp_data,
  output logic [$clog2(N_TAPS)-1:0] coef_addr,
  input  logic [DATA_W-1:0]         coef_data,
  output logic                      core_start,
  output logic                      core_in_vld,
  output logic [DATA_W-1:0]         core_x,
  output logic [DATA_W-1:0]         core_h,
  input  logic                      core_busy,
  input  logic                      core_done,
  input  logic [ACC_W-1:0]          core_res,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ACC_W-1:0]          res_data,
  output logic                      feed_busy,
  output logic                      err_tmo
);

  localparam int CW = $clog2(N_TAPS);
  localparam int TW = $clog2(TMO_CYC + 1);

  feed_state_e       state_r, state_s;
  logic [TW-1:0]     tmo_cnt_r, tmo_cnt_s;
  logic              tmo_hit_s;
  logic              load_s;
  logic [CW-1:0]     beat_cnt_s;
  logic              last_beat_s;

  logic [DATA_W-1:0] core_x_r, core_x_s;
  logic [DATA_W-1:0] core_h_r, core_h_s;
  logic              core_start_r, core_start_s;
  logic              core_in_vld_r, core_in_vld_s;
  logic [ACC_W-1:0]  res_data_r, res_data_s;
  logic              res_valid_r, res_valid_s;
  logic              feed_busy_r, feed_busy_s;
  logic              err_tmo_r, err_tmo_s;

  // The core busy flag carries no control meaning for the feeder.
  logic              unused_core_busy_s;
  assign unused_core_busy_s = core_busy;

  assign load_s    = (state_r == ST_IDLE) && frame_req;
  assign tmo_hit_s = (tmo_cnt_r == TW'(TMO_CYC - 1));

  hilbert_frame_feeder_addr_gen #(
    .ADDR_W (ADDR_W),
    .N_TAPS (N_TAPS),
    .CW     (CW)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_s),
    .base      (frame_base),
    .prefetch  (state_r == ST_PREFETCH),
    .stream    (state_r == ST_STREAM),
    .smp_addr  (smp_addr),
    .coef_addr (coef_addr),
    .beat_cnt  (beat_cnt_s),
    .last_beat (last_beat_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; requests outside IDLE and done outside WAIT_DONE are ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_req) state_s = ST_PREFETCH;
        else           state_s = ST_IDLE;
      end
      ST_PREFETCH: state_s = ST_STREAM;
      ST_STREAM: begin
        if (last_beat_s) state_s = ST_WAIT_DONE;
        else             state_s = ST_STREAM;
      end
      ST_WAIT_DONE: begin
        if (core_done)      state_s = ST_HOLD_RES;
        else if (tmo_hit_s) state_s = ST_IDLE;
        else                state_s = ST_WAIT_DONE;
      end
      ST_HOLD_RES: begin
        if (res_valid_r && res_ready) state_s = ST_IDLE;
        else                          state_s = ST_HOLD_RES;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and of the timeout counter.
  always_comb begin
    core_x_s      = core_x_r;
    core_h_s      = core_h_r;
    core_start_s  = 1'b0;
    core_in_vld_s = 1'b0;
    res_data_s    = res_data_r;
    res_valid_s   = 1'b0;
    err_tmo_s     = err_tmo_r;
    tmo_cnt_s     = {TW{1'b0}};
    feed_busy_s   = (state_s != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (frame_req) err_tmo_s = 1'b0;
        else           err_tmo_s = err_tmo_r;
      end
      ST_PREFETCH: begin
        core_in_vld_s = 1'b0;
      end
      ST_STREAM: begin
        core_x_s      = smp_data;
        core_h_s      = coef_data;
        core_in_vld_s = 1'b1;
        core_start_s  = (beat_cnt_s == {CW{1'b0}});
      end
      ST_WAIT_DONE: begin
        if (core_done) begin
          res_data_s  = core_res;
          res_valid_s = 1'b1;
        end else if (tmo_hit_s) begin
          err_tmo_s = 1'b1;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TW'(1);
        end
      end
      ST_HOLD_RES: begin
        if (res_ready) res_valid_s = 1'b0;
        else           res_valid_s = 1'b1;
      end
      default: begin
        res_valid_s = 1'b0;
      end
    endcase
  end

  // Output, result and timeout registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_x_r      <= {DATA_W{1'b0}};
      core_h_r      <= {DATA_W{1'b0}};
      core_start_r  <= 1'b0;
      core_in_vld_r <= 1'b0;
      res_data_r    <= {ACC_W{1'b0}};
      res_valid_r   <= 1'b0;
      feed_busy_r   <= 1'b0;
      err_tmo_r     <= 1'b0;
      tmo_cnt_r     <= {TW{1'b0}};
    end else begin
      core_x_r      <= core_x_s;
      core_h_r      <= core_h_s;
      core_start_r  <= core_start_s;
      core_in_vld_r <= core_in_vld_s;
      res_data_r    <= res_data_s;
      res_valid_r   <= res_valid_s;
      feed_busy_r   <= feed_busy_s;
      err_tmo_r     <= err_tmo_s;
      tmo_cnt_r     <= tmo_cnt_s;
    end
  end

  assign core_x      = core_x_r;
  assign core_h      = core_h_r;
  assign core_start  = core_start_r;
  assign core_in_vld = core_in_vld_r;
  assign res_data    = res_data_r;
  assign res_valid   = res_valid_r;
  assign feed_busy   = feed_busy_r;
  assign err_tmo     = err_tmo_r;

endmodule

// File: tb/tb_hilbert_frame_feeder.sv
// Self-checking bench for hilbert_frame_feeder: RAM models, a beat/result
// scoreboard filled at request time, and one task per scenario.
module tb_hilbert_frame_feeder;

  localparam int DATA_W  = 16;
  localparam int N_TAPS  = 16;
  localparam int ADDR_W  = 8;
  localparam int ACC_W   = 36;
  localparam int TMO_CYC = 255;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_req;
  logic [ADDR_W-1:0] frame_base;
  logic [ADDR_W-1:0] smp_addr;
  logic [DATA_W-1:0] smp_data;
  logic [3:0]        coef_addr;
  logic [DATA_W-1:0] coef_data;
  logic              core_start, core_in_vld;
  logic [DATA_W-1:0] core_x, core_h;
  logic              core_busy, core_done;
  logic [ACC_W-1:0]  core_res;
  logic              res_valid, res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              feed_busy, err_tmo;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] h;
    logic              st;
  } beat_t;

  beat_t             beat_q[$];
  logic [ACC_W-1:0]  res_q[$];
  logic [DATA_W-1:0] smp_mem [0:255];
  logic [DATA_W-1:0] coef_mem[0:N_TAPS-1];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  // Synchronous-read RAM models with one cycle of latency.
  always @(posedge clk) begin
    smp_data  <= smp_mem[smp_addr];
    coef_data <= coef_mem[coef_addr];
  end

  hilbert_frame_feeder #(
    .DATA_W(DATA_W), .N_TAPS(N_TAPS), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .TMO_CYC(TMO_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .frame_base(frame_base),
    .smp_addr(smp_addr), .smp_data(smp_data), .coef_addr(coef_addr), .coef_data(coef_data),
    .core_start(core_start), .core_in_vld(core_in_vld), .core_x(core_x), .core_h(core_h),
    .core_busy(core_busy), .core_done(core_done), .core_res(core_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .feed_busy(feed_busy), .err_tmo(err_tmo)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the beats the frame at 'base' must produce.
  task automatic expect_frame(input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] a;
    beat_t b;
    for (int k = 0; k < N_TAPS; k++) begin
      a    = base + ADDR_W'(k);
      b.x  = smp_mem[a];
      b.h  = coef_mem[k];
      b.st = (k == 0);
      beat_q.push_back(b);
    end
  endtask

  // Request a frame; returns in cycle 0 (just after the accepting edge).
  task automatic start_frame(input logic [ADDR_W-1:0] base);
    frame_req  = 1'b1;
    frame_base = base;
    tick();
    frame_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    chk_cnt++;
    if ({smp_addr, coef_addr, core_start, core_in_vld, core_x, core_h, res_valid, res_data, feed_busy, err_tmo} !== '0)
      $display("FAIL reset_hold: outputs=%h required all zero",
               {smp_addr, coef_addr, core_start, core_in_vld, core_x, core_h, res_valid, res_data, feed_busy, err_tmo});
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) tick();
    chk_cnt++;
    if ({core_in_vld, res_valid, feed_busy, err_tmo, smp_addr} !== '0)
      $display("FAIL reset_idle: flags/addr=%h required 0", {core_in_vld, res_valid, feed_busy, err_tmo, smp_addr});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    beat_t e;
    logic [ACC_W-1:0] r;
    for (int k = 0; k < N_TAPS; k++) begin
      smp_mem[8'h10 + k] = DATA_W'(k + 1);
      coef_mem[k]        = 16'h0001;
    end
    expect_frame(8'h10);
    start_frame(8'h10);
    chk_cnt++;
    if (feed_busy !== 1'b1) $display("FAIL basic_busy: got %b required 1", feed_busy);
    else pass_cnt++;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (core_in_vld) begin
        chk_cnt++;
        if (beat_q.size() == 0) $display("FAIL basic_beat: extra beat x=%h at cycle %0d", core_x, c);
        else begin
          e = beat_q.pop_front();
          if ({core_x, core_h, core_start} !== {e.x, e.h, e.st})
            $display("FAIL basic_beat: got x=%h h=%h st=%b required x=%h h=%h st=%b", core_x, core_h, core_start, e.x, e.h, e.st);
          else pass_cnt++;
        end
      end
      if (res_valid) break;
      if (c == 20) begin
        core_done = 1'b1;
        core_res  = 36'h9_8765_4321;
        res_q.push_back(core_res);
      end else core_done = 1'b0;
    end
    core_done = 1'b0;
    chk_cnt++;
    if (beat_q.size() != 0) $display("FAIL basic_count: %0d beats missing required 0", beat_q.size());
    else pass_cnt++;
    r = (res_q.size() != 0) ? res_q.pop_front() : '0;
    chk_cnt++;
    if (res_valid !== 1'b1 || res_data !== r) $display("FAIL basic_res: got v=%b d=%h required v=1 d=%h", res_valid, res_data, r);
    else pass_cnt++;
    repeat (2) tick();
    chk_cnt++;
    if (res_valid !== 1'b1 || res_data !== r) $display("FAIL basic_hold: got v=%b d=%h required v=1 d=%h", res_valid, res_data, r);
    else pass_cnt++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk_cnt++;
    if ({res_valid, feed_busy} !== 2'b00) $display("FAIL basic_accept: valid/busy=%b required 00", {res_valid, feed_busy});
    else pass_cnt++;
  endtask

  task automatic test_timing();
    beat_t e;
    int first_c = 0, last_c = 0, res_c = 0;
    for (int k = 0; k < N_TAPS; k++) begin
      smp_mem[8'h40 + k] = DATA_W'($urandom);
      coef_mem[k]        = DATA_W'($urandom);
    end
    expect_frame(8'h40);
    core_done = 1'b1;
    core_res  = 36'hA_BCDE_0123;
    res_q.push_back(core_res);
    start_frame(8'h40);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (core_in_vld) begin
        if (first_c == 0) first_c = c;
        last_c = c;
        chk_cnt++;
        if (beat_q.size() == 0) $display("FAIL timing_beat: extra beat at cycle %0d", c);
        else begin
          e = beat_q.pop_front();
          if ({core_x, core_h, core_start} !== {e.x, e.h, e.st})
            $display("FAIL timing_beat: got x=%h h=%h st=%b required x=%h h=%h st=%b", core_x, core_h, core_start, e.x, e.h, e.st);
          else pass_cnt++;
        end
      end
      if (res_valid) begin res_c = c; break; end
    end
    core_done = 1'b0;
    chk_cnt++;
    if (first_c != 2 || last_c != N_TAPS + 1)
      $display("FAIL timing_window: first=%0d last=%0d required first=2 last=%0d", first_c, last_c, N_TAPS + 1);
    else pass_cnt++;
    chk_cnt++;
    if (res_c != N_TAPS + 2) $display("FAIL timing_early_done: res_valid at %0d required %0d", res_c, N_TAPS + 2);
    else pass_cnt++;
    chk_cnt++;
    if (res_q.size() == 0 || res_data !== res_q[0]) $display("FAIL timing_res: got %h", res_data);
    else pass_cnt++;
    res_q.delete();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_wrap();
    beat_t e;
    logic [ADDR_W-1:0] ea;
    for (int a = 0; a < 256; a++) smp_mem[a] = {8'hA5, 8'(a)};
    for (int k = 0; k < N_TAPS; k++) coef_mem[k] = 16'hC000 | 16'(k);
    expect_frame(8'hF8);
    start_frame(8'hF8);
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) tick();
      if (c < N_TAPS) begin
        ea = 8'hF8 + 8'(c);
        chk_cnt++;
        if (smp_addr !== ea || coef_addr !== 4'(c))
          $display("FAIL wrap_addr: cycle %0d got %h/%h required %h/%h", c, smp_addr, coef_addr, ea, 4'(c));
        else pass_cnt++;
      end
      if (core_in_vld) begin
        chk_cnt++;
        if (beat_q.size() == 0) $display("FAIL wrap_beat: extra beat at cycle %0d", c);
        else begin
          e = beat_q.pop_front();
          if ({core_x, core_h} !== {e.x, e.h})
            $display("FAIL wrap_beat: got x=%h h=%h required x=%h h=%h", core_x, core_h, e.x, e.h);
          else pass_cnt++;
        end
      end
      if (res_valid) break;
      core_done = (c >= N_TAPS);
      core_res  = 36'h0_0000_F00D;
    end
    core_done = 1'b0;
    chk_cnt++;
    if (beat_q.size() != 0 || res_valid !== 1'b1 || res_data !== 36'h0_0000_F00D)
      $display("FAIL wrap_end: missing=%0d v=%b d=%h required 0 1 0000f00d", beat_q.size(), res_valid, res_data);
    else pass_cnt++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [ACC_W-1:0] r;
    beat_q.delete();
    core_done = 1'b1;
    core_res  = 36'h5_5AA5_3CC3;
    res_q.push_back(core_res);
    start_frame(8'h20);
    for (int c = 1; c <= 40 && !res_valid; c++) tick();
    core_done = 1'b0;
    core_res  = 36'h0;
    r = res_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      frame_req  = 1'b1;
      frame_base = 8'h99;
      tick();
      chk_cnt++;
      if (res_valid !== 1'b1 || res_data !== r || core_in_vld !== 1'b0)
        $display("FAIL bp_hold: cycle %0d got v=%b d=%h vld=%b required v=1 d=%h vld=0", i, res_valid, res_data, core_in_vld, r);
      else pass_cnt++;
    end
    frame_req = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk_cnt++;
    if ({res_valid, feed_busy} !== 2'b00) $display("FAIL bp_accept: valid/busy=%b required 00", {res_valid, feed_busy});
    else pass_cnt++;
    repeat (4) tick();
    chk_cnt++;
    if ({core_in_vld, feed_busy} !== 2'b00) $display("FAIL bp_no_queue: vld/busy=%b required 00", {core_in_vld, feed_busy});
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    beat_t e;
    int beats = 0;
    core_done = 1'b0;
    start_frame(8'h30);
    for (int c = 1; c <= N_TAPS + TMO_CYC + 5; c++) begin
      tick();
      if (c == N_TAPS + TMO_CYC) begin
        chk_cnt++;
        if ({err_tmo, feed_busy} !== 2'b01) $display("FAIL tmo_early: err/busy=%b required 01", {err_tmo, feed_busy});
        else pass_cnt++;
      end
      if (c == N_TAPS + TMO_CYC + 1) begin
        chk_cnt++;
        if ({err_tmo, feed_busy, res_valid} !== 3'b100)
          $display("FAIL tmo_flag: err/busy/valid=%b required 100", {err_tmo, feed_busy, res_valid});
        else pass_cnt++;
        break;
      end
    end
    repeat (3) tick();
    chk_cnt++;
    if (err_tmo !== 1'b1) $display("FAIL tmo_sticky: got %b required 1", err_tmo);
    else pass_cnt++;
    expect_frame(8'h30);
    core_done = 1'b1;
    core_res  = 36'h1_2345_6789;
    start_frame(8'h30);
    chk_cnt++;
    if (err_tmo !== 1'b0) $display("FAIL tmo_clear: got %b required 0", err_tmo);
    else pass_cnt++;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (core_in_vld && beat_q.size() != 0) begin
        e = beat_q.pop_front();
        beats++;
        chk_cnt++;
        if ({core_x, core_h, core_start} !== {e.x, e.h, e.st})
          $display("FAIL tmo_next_beat: got x=%h st=%b required x=%h st=%b", core_x, core_start, e.x, e.st);
        else pass_cnt++;
      end
      if (res_valid) break;
    end
    core_done = 1'b0;
    chk_cnt++;
    if (beats != N_TAPS || res_data !== 36'h1_2345_6789)
      $display("FAIL tmo_next_frame: beats=%0d d=%h required %0d 123456789", beats, res_data, N_TAPS);
    else pass_cnt++;
    beat_q.delete();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    beat_t e;
    int beats = 0;
    for (int k = 0; k < N_TAPS; k++) smp_mem[8'h50 + k] = 16'h7700 + 16'(k);
    expect_frame(8'h50);
    core_done = 1'b0;
    start_frame(8'h50);
    for (int c = 1; c <= 20 && beats < 8; c++) begin
      tick();
      if (core_in_vld) begin beats++; void'(beat_q.pop_front()); end
    end
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({smp_addr, coef_addr, core_start, core_in_vld, core_x, core_h, res_valid, res_data, feed_busy, err_tmo} !== '0)
      $display("FAIL rst_mid_async: outputs=%h required all zero",
               {smp_addr, coef_addr, core_start, core_in_vld, core_x, core_h, res_valid, res_data, feed_busy, err_tmo});
    else pass_cnt++;
    beat_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    expect_frame(8'h50);
    core_done = 1'b1;
    core_res  = 36'hF_0000_000F;
    start_frame(8'h50);
    beats = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (core_in_vld && beat_q.size() != 0) begin
        e = beat_q.pop_front();
        chk_cnt++;
        if (beats == 0 && c != 2) $display("FAIL rst_mid_first: first beat at cycle %0d required 2", c);
        else if ({core_x, core_h, core_start} !== {e.x, e.h, e.st})
          $display("FAIL rst_mid_beat: beat %0d got x=%h st=%b required x=%h st=%b", beats, core_x, core_start, e.x, e.st);
        else pass_cnt++;
        beats++;
      end
      if (res_valid) break;
    end
    core_done = 1'b0;
    chk_cnt++;
    if (beats != N_TAPS || res_data !== 36'hF_0000_000F)
      $display("FAIL rst_mid_frame: beats=%0d d=%h required %0d f0000000f", beats, res_data, N_TAPS);
    else pass_cnt++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    frame_req  = 1'b0;
    frame_base = '0;
    core_busy  = 1'b0;
    core_done  = 1'b0;
    core_res   = '0;
    res_ready  = 1'b0;
    for (int a = 0; a < 256; a++) smp_mem[a] = '0;
    for (int k = 0; k < N_TAPS; k++) coef_mem[k] = '0;
    test_reset();
    test_basic();
    test_timing();
    test_wrap();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
